// File: rtl/freq_meter_gate.sv
// Gated-window frequency meter: counts rising edges of an asynchronous input over GATE_CYCLES clk cycles.
// Define FREQ_METER_CONTINUOUS_EN to make the meter free-run back-to-back windows and ignore start.
module freq_meter_gate #(
    parameter int GATE_CYCLES = 100000000,
    parameter int GATE_W      = 27,
    parameter int EDGE_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sig_in,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [EDGE_W-1:0] freq_count,
    output logic              overflow
);

    // state   | meaning
    // IDLE    | waiting for start (continuous build: passes straight to ARM)
    // ARM     | one cycle, clears edge/gate counters and sticky overflow
    // MEASURE | GATE_CYCLES cycles, counts synchronised rising edges
    // DONE    | one cycle, done pulse with freshly latched result
    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE,
        S_DONE
    } state_t;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q, hist_q;
    logic                rise;
    logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
    logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d, edge_inc;
    logic                ovf_int_q, ovf_int_d, ovf_inc;
    logic [EDGE_W-1:0]   freq_count_q, freq_count_d;
    logic                overflow_q, overflow_d;

    assign rise       = sync2_q & ~hist_q;
    assign freq_count = freq_count_q;
    assign overflow   = overflow_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            hist_q       <= 1'b0;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            ovf_int_q    <= 1'b0;
            freq_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sig_in;
            sync2_q      <= sync1_q;
            hist_q       <= sync2_q;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            ovf_int_q    <= ovf_int_d;
            freq_count_q <= freq_count_d;
            overflow_q   <= overflow_d;
        end
    end

    // Saturating edge increment; a rise at all-ones only marks the window as overflowed.
    always_comb begin
        edge_inc = edge_cnt_q;
        ovf_inc  = ovf_int_q;
        if (rise) begin
            if (&edge_cnt_q) begin
                ovf_inc = 1'b1;
            end else begin
                edge_inc = edge_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gate_cnt_d   = gate_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        ovf_int_d    = ovf_int_q;
        freq_count_d = freq_count_q;
        overflow_d   = overflow_q;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            S_IDLE: begin
`ifdef FREQ_METER_CONTINUOUS_EN
                state_d = S_ARM;
`else
                if (start) begin
                    state_d = S_ARM;
                end
`endif
            end
            S_ARM: begin
                busy       = 1'b1;
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                ovf_int_d  = 1'b0;
                state_d    = S_MEASURE;
            end
            S_MEASURE: begin
                busy       = 1'b1;
                gate_cnt_d = gate_cnt_q + 1'b1;
                edge_cnt_d = edge_inc;
                ovf_int_d  = ovf_inc;
                // Latch from the incremented values so a rise in the final cycle still counts.
                if (gate_cnt_q == GATE_LAST) begin
                    freq_count_d = edge_inc;
                    overflow_d   = ovf_inc;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
`ifdef FREQ_METER_CONTINUOUS_EN
                state_d = S_ARM;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
